rand_arbiter_32: RTL and testbench

RAND_ARBITER_32 -- requirements
Module: rand_arbiter_32

---
 rtl/rand_arbiter_32.sv | 131 +++++++++++++
 tb/tb_rand_arbiter_32.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rand_arbiter_32.sv
`default_nettype none
// ============================================================================
//  Module      : rand_arbiter_32
//  Description : Two-requester round-robin arbiter that advances a 32-bit
//                Galois LFSR a fixed number of steps for every grant and
//                presents a fresh random word alongside the grant pulse.
//  Revision    : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    STEPS     : LFSR advances per grant (1..15)
//    TAPS      : Galois feedback mask (default x^32+x^22+x^2+x+1)
//  Ports
//    clk       in   1   system clock, rising edge
//    clr       in   1   asynchronous active-high reset
//    seed_load in   1   load seed into the LFSR (highest priority)
//    seed      in  32   seed value (0 is replaced by 1)
//    req       in   2   request lines
//    gnt       out  2   one-hot grant, registered, one cycle wide
//    valid     out  1   rnd holds a fresh value, registered
//    rnd       out 32   current LFSR contents
//    busy      out  1   FSM is not idle
// ============================================================================
module rand_arbiter_32 #(
   parameter int          STEPS = 2,
   parameter logic [31:0] TAPS  = 32'h80200003
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        seed_load,
   input  logic [31:0] seed,
   input  logic [1:0]  req,
   output logic [1:0]  gnt,
   output logic        valid,
   output logic [31:0] rnd,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_STEP  = 2'd1,
      S_GRANT = 2'd2
   } state_t;

   localparam logic [3:0]  c_LAST_CNT = 4'(STEPS - 1);
   localparam logic [31:0] c_LFSR_RST = 32'h00000001;

   state_t      r_state;
   logic [31:0] r_lfsr;
   logic [3:0]  r_cnt;
   logic        r_ptr;
   logic        r_win;
   logic [1:0]  r_gnt;
   logic        r_valid;

   logic [31:0] w_lfsr_adv;
   logic [31:0] w_seed_val;
   logic        w_win;
   logic        w_last_step;

   // One Galois advance: shift right, fold the taps back in when a 1 falls out.
   assign w_lfsr_adv  = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);

   // An all-zero LFSR would never leave zero, so a zero seed becomes 1.
   assign w_seed_val  = (seed == 32'd0) ? c_LFSR_RST : seed;

   // Contention goes to the pointer; otherwise the single active line wins.
   assign w_win       = (req == 2'b11) ? r_ptr : req[1];

   assign w_last_step = (r_cnt == c_LAST_CNT);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= S_IDLE;
         r_lfsr  <= c_LFSR_RST;
         r_cnt   <= 4'd0;
         r_ptr   <= 1'b0;
         r_win   <= 1'b0;
         r_gnt   <= 2'b00;
         r_valid <= 1'b0;
      end else if (seed_load) begin
         // Seed load aborts any sequence in flight; the pointer is left alone
         // so an aborted requester keeps its turn.
         r_state <= S_IDLE;
         r_lfsr  <= w_seed_val;
         r_cnt   <= 4'd0;
         r_gnt   <= 2'b00;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_gnt   <= 2'b00;
               r_valid <= 1'b0;
               if (req != 2'b00) begin
                  r_win   <= w_win;
                  r_cnt   <= 4'd0;
                  r_state <= S_STEP;
               end
            end
            S_STEP: begin
               r_lfsr <= w_lfsr_adv;
               r_cnt  <= r_cnt + 4'd1;
               if (w_last_step) begin
                  // Grant is raised on the same edge as the final advance so
                  // rnd and gnt become visible together.
                  r_state <= S_GRANT;
                  r_gnt   <= r_win ? 2'b10 : 2'b01;
                  r_valid <= 1'b1;
               end
            end
            S_GRANT: begin
               r_gnt   <= 2'b00;
               r_valid <= 1'b0;
               r_ptr   <= ~r_win;
               r_state <= S_IDLE;
            end
            default: begin
               r_gnt   <= 2'b00;
               r_valid <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt   = r_gnt;
   assign valid = r_valid;
   assign rnd   = r_lfsr;
   assign busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rand_arbiter_32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rand_arbiter_32
//  Description : Self-checking bench for rand_arbiter_32. A transaction-level
//                reference model tracks the LFSR value, the round-robin
//                pointer and the age of the grant in flight.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_rand_arbiter_32;

   localparam int          STEPS = 2;
   localparam logic [31:0] TAPS  = 32'h80200003;

   logic        clk;
   logic        clr;
   logic        seed_load;
   logic [31:0] seed;
   logic [1:0]  req;
   logic [1:0]  gnt;
   logic        valid;
   logic [31:0] rnd;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: age = edges since the request was accepted,
   // -1 when no transaction is in flight.
   logic [31:0] m_lfsr;
   logic        m_ptr;
   logic        m_win;
   int          m_age;
   logic [1:0]  last_gnt;

   rand_arbiter_32 #(.STEPS(STEPS), .TAPS(TAPS)) dut (
      .clk       (clk),
      .clr       (clr),
      .seed_load (seed_load),
      .seed      (seed),
      .req       (req),
      .gnt       (gnt),
      .valid     (valid),
      .rnd       (rnd),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] lfsr_next(input logic [31:0] x);
      if (x % 2 == 1) return (x / 2) ^ TAPS;
      else            return x / 2;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_lfsr = 32'h00000001;
      m_ptr  = 1'b0;
      m_win  = 1'b0;
      m_age  = -1;
   endtask

   // Model reaction to one rising edge with the given inputs.
   task automatic model_edge(input logic [1:0] r, input logic sl, input logic [31:0] sd);
      if (sl) begin
         m_lfsr = (sd == 0) ? 32'h1 : sd;
         m_age  = -1;
      end else if (m_age < 0) begin
         if (r != 2'b00) begin
            if (r == 2'b11) m_win = m_ptr;
            else            m_win = (r == 2'b10);
            m_age = 0;
         end
      end else begin
         m_age++;
         if (m_age <= STEPS) m_lfsr = lfsr_next(m_lfsr);
         if (m_age == STEPS + 1) begin
            m_ptr = ~m_win;
            m_age = -1;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      logic       e_valid;
      logic [1:0] e_gnt;
      e_valid = (m_age == STEPS);
      e_gnt   = e_valid ? (m_win ? 2'b10 : 2'b01) : 2'b00;
      chk({tag, ".rnd"},   rnd,   m_lfsr);
      chk({tag, ".gnt"},   {30'd0, gnt},   {30'd0, e_gnt});
      chk({tag, ".valid"}, {31'd0, valid}, {31'd0, e_valid});
      chk({tag, ".busy"},  {31'd0, busy},  {31'd0, (m_age >= 0)});
   endtask

   // Apply inputs for one cycle, advance the model, sample away from the edge.
   task automatic tick(input string tag, input logic [1:0] r, input logic sl, input logic [31:0] sd);
      req       = r;
      seed_load = sl;
      seed      = sd;
      @(posedge clk);
      model_edge(r, sl, sd);
      #1;
      check_outputs(tag);
   endtask

   initial begin
      int grants;
      req       = 2'b00;
      seed_load = 1'b0;
      seed      = 32'd0;
      last_gnt  = 2'b00;
      model_reset();

      // Asynchronous reset visible before any clock edge.
      clr = 1'b1;
      #1;
      check_outputs("reset");
      @(posedge clk);
      #1;
      clr = 1'b0;

      // Single request from requester 0: two advances then a one-cycle grant.
      tick("r01", 2'b01, 1'b0, 32'd0);
      tick("r01", 2'b00, 1'b0, 32'd0);
      chk("r01.adv1", rnd, 32'h80200003);
      tick("r01", 2'b00, 1'b0, 32'd0);
      chk("r01.rnd_at_gnt", rnd, 32'hC0300002);
      chk("r01.gnt_onehot", {30'd0, gnt}, 32'd1);
      for (int i = 0; i < 3; i++) tick("r01.tail", 2'b00, 1'b0, 32'd0);

      // Continuous contention: grants must alternate.
      grants = 0;
      for (int i = 0; i < 17; i++) begin
         tick("r11", 2'b11, 1'b0, 32'd0);
         if (valid === 1'b1) begin
            if (last_gnt != 2'b00) chk("r11.alternate", {30'd0, gnt}, {30'd0, ~last_gnt});
            last_gnt = gnt;
            grants++;
         end
      end
      chk("r11.grant_count", grants, 4);
      for (int i = 0; i < 2; i++) tick("r11.drain", 2'b00, 1'b0, 32'd0);

      // Seed loads, including the zero-seed substitution.
      tick("seed0", 2'b00, 1'b1, 32'd0);
      chk("seed0.rnd", rnd, 32'h00000001);
      tick("seedX", 2'b00, 1'b1, 32'h12345678);
      chk("seedX.rnd", rnd, 32'h12345678);

      // Seed load during STEP aborts without a grant.
      tick("abort", 2'b01, 1'b0, 32'd0);
      tick("abort", 2'b00, 1'b0, 32'd0);
      tick("abort.load", 2'b00, 1'b1, 32'hCAFEF00D);
      chk("abort.rnd", rnd, 32'hCAFEF00D);
      for (int i = 0; i < 4; i++) tick("abort.idle", 2'b00, 1'b0, 32'd0);

      // Request together with seed load in IDLE: load only, serve afterwards.
      tick("reqload", 2'b10, 1'b1, 32'hA5A5A5A5);
      for (int i = 0; i < 5; i++) tick("reqload.serve", 2'b10, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) tick("reqload.drain", 2'b00, 1'b0, 32'd0);

      // Asynchronous clear between edges during STEP.
      tick("aclr", 2'b01, 1'b0, 32'd0);
      req = 2'b00;
      #3;
      clr = 1'b1;
      #1;
      model_reset();
      check_outputs("aclr.mid");
      #1;
      clr = 1'b0;
      for (int i = 0; i < 4; i++) tick("aclr.after", 2'b00, 1'b0, 32'd0);

      // Requester 1 drops its request after one cycle but is still granted.
      tick("drop", 2'b10, 1'b0, 32'd0);
      for (int i = 0; i < 6; i++) tick("drop.rest", 2'b00, 1'b0, 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic        sl;
         logic [31:0] sd;
         sl = ($urandom_range(0, 15) == 0);
         sd = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         tick("rand", 2'($urandom_range(0, 3)), sl, sd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
